// File: rtl/sm_addsub_pipe_if.sv
// Valid/ready operand and result bus for the sign-magnitude add/sub pipeline.
// Drivers use the master modport and the datapath uses the slave modport.
interface sm_addsub_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, ovf, zero
  );
endinterface

// File: rtl/sm_addsub_pipe.sv
// Two-stage sign-magnitude adder/subtractor with valid/ready handshakes and no -0 output.
// Define SM_ADDSUB_SAT_EN to saturate add overflow instead of wrapping.
module sm_addsub_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  sm_addsub_pipe_if.slave bus
);
  localparam int unsigned M = WIDTH - 1;

  typedef struct packed {
    logic [M-1:0] max;
    logic [M-1:0] min;
    logic         rsign;
    logic         eff_add;
  } s1_t;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             sb_c;
  logic [M-1:0]     ma_c, mb_c;
  s1_t              s1_new_c;
  logic             s1_adv_c, in_ready_c;
  logic [M:0]       add_full_c;
  logic [M-1:0]     mag_c;
  logic             ovf_c, zero_c, sign_c;

  // S1 decode: order magnitudes so the S2 subtract never goes negative
  always_comb begin
    sb_c     = bus.b[WIDTH-1] ^ bus.sub;
    ma_c     = bus.a[M-1:0];
    mb_c     = bus.b[M-1:0];
    s1_new_c = '0;
    s1_new_c.eff_add = (bus.a[WIDTH-1] == sb_c);
    if (ma_c > mb_c) begin
      s1_new_c.max   = ma_c;
      s1_new_c.min   = mb_c;
      s1_new_c.rsign = bus.a[WIDTH-1];
    end else begin
      s1_new_c.max   = mb_c;
      s1_new_c.min   = ma_c;
      s1_new_c.rsign = sb_c;
    end
  end

  // Handshake: S1 may load when empty or when S2 is draining this cycle
  always_comb begin
    s1_adv_c   = !out_valid_q || bus.out_ready;
    in_ready_c = !s1_valid_q || s1_adv_c;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_ready_c) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d = s1_new_c;
      end
    end
  end

  // S2 compute and zero normalisation
  always_comb begin
    add_full_c = {1'b0, s1_q.max} + {1'b0, s1_q.min};
    mag_c      = '0;
    ovf_c      = 1'b0;
    if (s1_q.eff_add) begin
      mag_c = add_full_c[M-1:0];
      ovf_c = add_full_c[M];
`ifdef SM_ADDSUB_SAT_EN
      if (ovf_c) begin
        mag_c = '1;
      end
`else
`endif
    end else begin
      mag_c = s1_q.max - s1_q.min;
    end
    zero_c = (mag_c == '0);
    sign_c = s1_q.rsign & ~zero_c;
  end

  // Output stage holds its beat until the consumer takes it
  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    if (s1_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d  = {sign_c, mag_c};
        ovf_d  = ovf_c;
        zero_d = zero_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Self-checking bench for sm_addsub_pipe (WIDTH=4) against a signed-integer reference model.
// Honours SM_ADDSUB_SAT_EN the same way as the design.
module tb_sm_addsub_pipe;
  localparam int unsigned W = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         ovf;
    logic         zero;
    int           k;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_addsub_pipe_if #(.WIDTH(W)) bus ();
  sm_addsub_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   xfer_cyc[$];
  logic acc;
  logic saw_ir_low;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: real signed arithmetic, then magnitude wrap or clamp
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int va, vb, r, mag;
    va = int'(a[W-2:0]);
    vb = int'(b[W-2:0]);
    if (a[W-1]) va = -va;
    if (b[W-1]) vb = -vb;
    r   = s ? va - vb : va + vb;
    mag = (r < 0) ? -r : r;
    e.ovf = (mag > 7);
`ifdef SM_ADDSUB_SAT_EN
    if (mag > 7) mag = 7;
`else
    mag = mag % 8;
`endif
    e.zero = (mag == 0);
    e.sum  = {(r < 0) && (mag != 0), 3'(mag)};
    e.k    = 0;
    return e;
  endfunction

  // One clock: drive, check against model, capture handshakes, advance
  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ordy);
    exp_t e;
    logic ov_exp;
    bus.in_valid = v; bus.a = a; bus.b = b; bus.sub = s; bus.out_ready = ordy;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'((exp_q.size() < 2) || ordy));
    ov_exp = (exp_q.size() > 0) && (exp_q[0].k <= cyc - 2);
    chk("out_valid", 32'(bus.out_valid), 32'(ov_exp));
    if (ov_exp && bus.out_valid) begin
      chk("sum", 32'(bus.sum), 32'(exp_q[0].sum));
      chk("ovf", 32'(bus.ovf), 32'(exp_q[0].ovf));
      chk("zero", 32'(bus.zero), 32'(exp_q[0].zero));
      if (ordy) begin
        void'(exp_q.pop_front());
        xfer_cyc.push_back(cyc);
      end
    end
    if (!bus.in_ready) saw_ir_low = 1'b1;
    acc = v && bus.in_ready;
    if (acc) begin
      e = model(a, b, s);
      e.k = cyc;
      exp_q.push_back(e);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] es, input logic eo, input logic ez);
    cycle(1'b1, a, b, s, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(ez));
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] ta[5];
    logic [W-1:0] tb[5];
    logic         ts[5];
    int           idx;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors with literal expectations
    one_beat("t1", 4'b0011, 4'b0010, 1'b0, 4'b0101, 1'b0, 1'b0);
    one_beat("t2a", 4'b0011, 4'b1101, 1'b0, 4'b1010, 1'b0, 1'b0);
`ifdef SM_ADDSUB_SAT_EN
    one_beat("t2b", 4'b0011, 4'b1101, 1'b1, 4'b0111, 1'b1, 1'b0);
    one_beat("t4", 4'b0110, 4'b0101, 1'b0, 4'b0111, 1'b1, 1'b0);
    one_beat("neg_ovf", 4'b1100, 4'b1100, 1'b0, 4'b1111, 1'b1, 1'b0);
`else
    one_beat("t2b", 4'b0011, 4'b1101, 1'b1, 4'b0000, 1'b1, 1'b1);
    one_beat("t4", 4'b0110, 4'b0101, 1'b0, 4'b0011, 1'b1, 1'b0);
    one_beat("neg_ovf", 4'b1100, 4'b1100, 1'b0, 4'b0000, 1'b1, 1'b1);
`endif
    one_beat("t3a", 4'b1011, 4'b1011, 1'b1, 4'b0000, 1'b0, 1'b1);
    one_beat("t3b", 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    one_beat("negz", 4'b0000, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1);
    one_beat("max_neg", 4'b1110, 4'b1001, 1'b0, 4'b1111, 1'b0, 1'b0);

    // Five back-to-back beats against a 4-cycle stall
    for (int i = 0; i < 5; i++) begin
      ta[i] = 4'($urandom); tb[i] = 4'($urandom); ts[i] = 1'($urandom);
    end
    xfer_cyc.delete();
    saw_ir_low = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (idx < 5) cycle(1'b1, ta[idx], tb[idx], ts[idx], (c >= 4));
      else         cycle(1'b0, '0, '0, 1'b0, (c >= 4));
      if (acc) idx++;
    end
    chk("t5_accepted", 32'(idx), 32'd5);
    chk("t5_in_ready_dropped", 32'(saw_ir_low), 32'd1);
    chk("t5_count", 32'(xfer_cyc.size()), 32'd5);
    if (xfer_cyc.size() == 5) chk("t5_no_gap", 32'(xfer_cyc[4] - xfer_cyc[0]), 32'd4);

    // Reset with two beats in flight
    cycle(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0);
    cycle(1'b1, 4'b0010, 4'b0001, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_sum", 32'(bus.sum), 32'd0);
    exp_q.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 4; c++) cycle(1'b0, '0, '0, 1'b0, 1'b1);

    // Randomised traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      cycle(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 6; c++) cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
